cpu_trace_checker: RTL and testbench
====================================

// Module: cpu_trace_checker
// PURPOSE
//   Streaming checker for CPU trace lines, one ASCII char per clk. It parses register-write
//   lines "^T@PPPPPPPP: $R <= DDDDDDDD#" and memory-write lines "^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#".
//   For each completed line it reports the format and an error vector, latches the parsed
//   fields, and keeps running line/error counts.
//   Sits on the trace bus between CPU testbench output and the scoreboard.
//   Generalises the fixed checker with parametrised ranges and digit limits, '^' resync, field capture and counters.
// PARAMETERS
//   TIME_DIGITS  4         max decimal digits of T (min 1)
//   GRF_DIGITS   4         max decimal digits of R (min 1)
//   GRF_NUM      32        legal register indices 0..GRF_NUM-1
//   PC_MIN       32'h3000  lowest legal PC (inclusive)
//   PC_MAX       32'h4fff  highest legal PC (inclusive)
//   ADDR_MIN     32'h0     lowest legal data address (inclusive)
//   ADDR_MAX     32'h2fff  highest legal data address (inclusive)
//   HEX_UPPER    0         1: hex fields also accept 'A'-'F'
//   CNT_W        16        width of line/error counters
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-low reset
//   char         in   8      ASCII input, sampled every clk
//   freq         in   16     cycle frequency; time must be a multiple of 2^(floor(log2 freq)-1)
//   cnt_clr      in   1      synchronous clear of line_cnt/err_cnt
//   format_type  out  2      0 none, 1 register line, 2 memory line
//   error_code   out  4      [0] time, [1] pc, [2] addr, [3] grf; 0 when format_type==0
//   cap_time     out  32     T of last completed line (binary)
//   cap_pc       out  32     PC of last completed line
//   cap_tgt      out  32     R (zero-extended) or A of last completed line
//   cap_data     out  32     D of last completed line
//   line_cnt     out  CNT_W  completed lines, saturating
//   err_cnt      out  CNT_W  completed lines with error_code!=0, saturating
// BEHAVIOUR
//   - Reset (reset==0, any time): FSM->IDLE; all outputs and capture/accumulator regs = 0.
//   - FSM: IDLE, TIME, PC, COLON_SP, GRF, GRF_SP, ADDR, ADDR_SP, LT, EQ_SP, DATA, DONE1, DONE2.
//   - IDLE: '^'->TIME. Any other char stays in IDLE.
//   - Resync: '^' in any state clears the digit counters and goes to TIME. A partial line in progress is dropped.
//   - TIME: 1..TIME_DIGITS decimal digits, accumulated as t*10+d. '@' ends the field; '@' with 0 digits ->IDLE.
//     A digit beyond TIME_DIGITS ->IDLE.
//   - PC: exactly 8 hex digits, then ':'; fewer or more ->IDLE. COLON_SP: spaces* then '$'->GRF or '*'->ADDR.
//   - GRF: 1..GRF_DIGITS decimal digits, then optional spaces, then '<'. ADDR: exactly 8 hex digits, then spaces*, then '<'.
//   - LT: '<' must be followed immediately by '='. EQ_SP: spaces* then 8 hex digits, then '#'. Hex count !=8 ->IDLE.
//   - Any character not permitted by the grammar above ->IDLE; that character is not reinterpreted.
//   - '#' accepted: next state is DONE1 (register line) or DONE2 (memory line).
//     The same edge loads cap_* and updates the counters (saturate at all-ones; cnt_clr has priority over increment).
//   - format_type/error_code are combinational from state and are nonzero only in DONE1/DONE2. That is one cycle
//     after '#', held until the next char is sampled. DONE* then: '^'->TIME, else ->IDLE.
//   - pw = floor(log2(freq))-1, clamped to 0 when freq<4. err[0] = (T mod 2^pw)!=0.
//     pw is computed from freq sampled on the '#' edge.
//   - err[1] = PC[1:0]!=0 || PC<PC_MIN || PC>PC_MAX.
//   - err[2] (DONE2 only) = A[1:0]!=0 || A<ADDR_MIN || A>ADDR_MAX.
//   - err[3] (DONE1 only) = R>=GRF_NUM.
//   - Arithmetic: unsigned, 32-bit accumulators; overflow is impossible within the digit limits.
//   - Hex digits: '0'-'9', 'a'-'f' ('A'-'F' only when HEX_UPPER=1).
// TESTING
//   - freq=4, "^10@00003000: $3 <= 0000abcd#" -> next cycle format_type=1, error_code=0,
//     cap_time=10, cap_tgt=3, cap_data=32'h0000abcd, line_cnt=1.
//   - freq=8, "^6@00003001: *00003000 <= 00000001#" -> format_type=2, error_code=4'b0111, err_cnt=1.
//   - "^5@00003000: $32 <= 00000000#" with freq=2 -> format_type=1, error_code=4'b1000.
//     Same line with "$12345" -> no report, FSM back in IDLE.
//   - "^1@0000300^2@00003004: $1<=00000000#" -> single report for T=2, no error;
//     "@0000300" followed by ':' with 7 digits -> dropped.
//   - Two back-to-back lines, no gap between '#' and '^' -> two one-cycle reports; line_cnt=2.
//   - Assert reset low mid-ADDR -> all outputs 0 immediately; after release, a full valid line reports normally.
//   - Drive line_cnt to all-ones -> stays saturated; cnt_clr=1 together with a '#' edge -> line_cnt=0.

Source files
------------

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker: streaming parser/checker for CPU trace lines, one ASCII character per clock.
// Accepts register-write lines "^T@PPPPPPPP: $R <= DDDDDDDD#" and memory-write lines
// "^T@PPPPPPPP: *AAAAAAAA <= DDDDDDDD#". For each completed line it reports the format and an
// error vector for one cycle, latches the parsed fields, and keeps saturating line/error counts.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   char        ASCII input, sampled every clock
//   freq        cycle frequency; T must be a multiple of 2^(floor(log2 freq)-1)
//   cnt_clr     synchronous clear of line_cnt/err_cnt (wins over increment)
//   format_type 0 none, 1 register line, 2 memory line
//   error_code  [0] time, [1] pc, [2] addr, [3] grf; zero when format_type==0
//   cap_time/cap_pc/cap_tgt/cap_data  fields of the last completed line
//   line_cnt    completed lines; err_cnt  completed lines with errors (both saturating)
module cpu_trace_checker #(
    parameter int unsigned TIME_DIGITS = 4,
    parameter int unsigned GRF_DIGITS  = 4,
    parameter int unsigned GRF_NUM     = 32,
    parameter logic [31:0] PC_MIN      = 32'h3000,
    parameter logic [31:0] PC_MAX      = 32'h4fff,
    parameter logic [31:0] ADDR_MIN    = 32'h0,
    parameter logic [31:0] ADDR_MAX    = 32'h2fff,
    parameter bit          HEX_UPPER   = 1'b0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    input  logic             cnt_clr,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [31:0]      cap_time,
    output logic [31:0]      cap_pc,
    output logic [31:0]      cap_tgt,
    output logic [31:0]      cap_data,
    output logic [CNT_W-1:0] line_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [3:0] {
        StIdle, StTime, StPc, StColonSp, StGrf, StGrfSp, StAddr, StAddrSp,
        StLt, StEqSp, StData, StDone1, StDone2
    } state_e;

    localparam logic [7:0] TimeMax = 8'(TIME_DIGITS);
    localparam logic [7:0] GrfMax  = 8'(GRF_DIGITS);
    localparam logic [31:0] GrfNum = 32'(GRF_NUM);

    state_e state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [31:0]      t_acc_q, t_acc_d, pc_acc_q, pc_acc_d;
    logic [31:0]      tgt_acc_q, tgt_acc_d, data_acc_q, data_acc_d;
    logic             is_mem_q, is_mem_d;
    logic [3:0]       err_q, err_d;
    logic [31:0]      cap_time_q, cap_time_d, cap_pc_q, cap_pc_d;
    logic [31:0]      cap_tgt_q, cap_tgt_d, cap_data_q, cap_data_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d, err_cnt_q, err_cnt_d;

    logic        is_dec, is_hex, accept;
    logic [3:0]  dig;
    logic [4:0]  pw;
    logic [31:0] t_mask;
    logic [3:0]  err_now;

    // True when v lies outside [lo, hi]; 33-bit differences avoid constant-compare corner cases.
    function automatic logic out_of_range(input logic [31:0] v, input logic [31:0] lo,
                                          input logic [31:0] hi);
        logic [32:0] below;
        logic [32:0] above;
        below = {1'b0, v} - {1'b0, lo};
        above = {1'b0, hi} - {1'b0, v};
        return below[32] | above[32];
    endfunction

    always_comb begin
        is_dec = (char >= "0") && (char <= "9");
        is_hex = is_dec || ((char >= "a") && (char <= "f")) ||
                 (HEX_UPPER && (char >= "A") && (char <= "F"));
        // 'a'/'A' have low nibble 1, so +9 maps letters onto 10..15.
        dig    = is_dec ? char[3:0] : (char[3:0] + 4'd9);
    end

    // Power-of-two granularity of T derived from freq.
    always_comb begin
        logic [4:0] msb;
        msb = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (freq[i]) msb = 5'(i);
        end
        pw      = (freq < 16'd4) ? 5'd0 : (msb - 5'd1);
        t_mask  = (32'd1 << pw) - 32'd1;
        err_now[0] = |(t_acc_q & t_mask);
        err_now[1] = (pc_acc_q[1:0] != 2'b00) || out_of_range(pc_acc_q, PC_MIN, PC_MAX);
        err_now[2] = is_mem_q &&
                     ((tgt_acc_q[1:0] != 2'b00) || out_of_range(tgt_acc_q, ADDR_MIN, ADDR_MAX));
        err_now[3] = !is_mem_q && (tgt_acc_q >= GrfNum);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        t_acc_d    = t_acc_q;
        pc_acc_d   = pc_acc_q;
        tgt_acc_d  = tgt_acc_q;
        data_acc_d = data_acc_q;
        is_mem_d   = is_mem_q;
        accept     = 1'b0;
        if (char == "^") begin
            // Resync from any state; a partial line is dropped.
            state_d = StTime;
            cnt_d   = 8'd0;
            t_acc_d = 32'd0;
        end else begin
            case (state_q)
                StIdle: state_d = StIdle;
                StTime: begin
                    if (is_dec && cnt_q < TimeMax) begin
                        t_acc_d = t_acc_q * 32'd10 + {28'd0, dig};
                        cnt_d   = cnt_q + 8'd1;
                    end else if (char == "@" && cnt_q != 8'd0) begin
                        state_d  = StPc;
                        cnt_d    = 8'd0;
                        pc_acc_d = 32'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StPc: begin
                    if (is_hex && cnt_q < 8'd8) begin
                        pc_acc_d = {pc_acc_q[27:0], dig};
                        cnt_d    = cnt_q + 8'd1;
                    end else if (char == ":" && cnt_q == 8'd8) begin
                        state_d = StColonSp;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StColonSp: begin
                    if (char == "$" || char == "*") begin
                        state_d   = (char == "$") ? StGrf : StAddr;
                        is_mem_d  = (char == "*");
                        cnt_d     = 8'd0;
                        tgt_acc_d = 32'd0;
                    end else if (char != " ") begin
                        state_d = StIdle;
                    end
                end
                StGrf: begin
                    if (is_dec && cnt_q < GrfMax) begin
                        tgt_acc_d = tgt_acc_q * 32'd10 + {28'd0, dig};
                        cnt_d     = cnt_q + 8'd1;
                    end else if (char == " " && cnt_q != 8'd0) begin
                        state_d = StGrfSp;
                    end else if (char == "<" && cnt_q != 8'd0) begin
                        state_d = StLt;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StAddr: begin
                    if (is_hex && cnt_q < 8'd8) begin
                        tgt_acc_d = {tgt_acc_q[27:0], dig};
                        cnt_d     = cnt_q + 8'd1;
                    end else if (char == " " && cnt_q == 8'd8) begin
                        state_d = StAddrSp;
                    end else if (char == "<" && cnt_q == 8'd8) begin
                        state_d = StLt;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StGrfSp, StAddrSp: begin
                    if (char == "<") state_d = StLt;
                    else if (char != " ") state_d = StIdle;
                end
                StLt: state_d = (char == "=") ? StEqSp : StIdle;
                StEqSp: begin
                    if (is_hex) begin
                        state_d    = StData;
                        data_acc_d = {28'd0, dig};
                        cnt_d      = 8'd1;
                    end else if (char != " ") begin
                        state_d = StIdle;
                    end
                end
                StData: begin
                    if (is_hex && cnt_q < 8'd8) begin
                        data_acc_d = {data_acc_q[27:0], dig};
                        cnt_d      = cnt_q + 8'd1;
                    end else if (char == "#" && cnt_q == 8'd8) begin
                        state_d = is_mem_q ? StDone2 : StDone1;
                        accept  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        err_d      = err_q;
        cap_time_d = cap_time_q;
        cap_pc_d   = cap_pc_q;
        cap_tgt_d  = cap_tgt_q;
        cap_data_d = cap_data_q;
        line_cnt_d = line_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (accept) begin
            err_d      = err_now;
            cap_time_d = t_acc_q;
            cap_pc_d   = pc_acc_q;
            cap_tgt_d  = tgt_acc_q;
            cap_data_d = data_acc_q;
            if (line_cnt_q != '1) line_cnt_d = line_cnt_q + CNT_W'(1);
            if (err_now != 4'd0 && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (cnt_clr) begin
            line_cnt_d = '0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            t_acc_q    <= 32'd0;
            pc_acc_q   <= 32'd0;
            tgt_acc_q  <= 32'd0;
            data_acc_q <= 32'd0;
            is_mem_q   <= 1'b0;
            err_q      <= 4'd0;
            cap_time_q <= 32'd0;
            cap_pc_q   <= 32'd0;
            cap_tgt_q  <= 32'd0;
            cap_data_q <= 32'd0;
            line_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            t_acc_q    <= t_acc_d;
            pc_acc_q   <= pc_acc_d;
            tgt_acc_q  <= tgt_acc_d;
            data_acc_q <= data_acc_d;
            is_mem_q   <= is_mem_d;
            err_q      <= err_d;
            cap_time_q <= cap_time_d;
            cap_pc_q   <= cap_pc_d;
            cap_tgt_q  <= cap_tgt_d;
            cap_data_q <= cap_data_d;
            line_cnt_q <= line_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        format_type = (state_q == StDone1) ? 2'd1 : (state_q == StDone2) ? 2'd2 : 2'd0;
        error_code  = (format_type != 2'd0) ? err_q : 4'd0;
    end

    assign cap_time = cap_time_q;
    assign cap_pc   = cap_pc_q;
    assign cap_tgt  = cap_tgt_q;
    assign cap_data = cap_data_q;
    assign line_cnt = line_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Scoreboard bench for cpu_trace_checker: directed trace lines push hand-computed expected
// reports into a queue; a monitor on the falling edge pops and compares each report.
module tb_cpu_trace_checker;

    localparam int unsigned CntW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [7:0]      char = 8'h20;
    logic [15:0]     freq = 16'd4;
    logic            cnt_clr = 1'b0;
    logic [1:0]      format_type;
    logic [3:0]      error_code;
    logic [31:0]     cap_time, cap_pc, cap_tgt, cap_data;
    logic [CntW-1:0] line_cnt, err_cnt;

    cpu_trace_checker #(.CNT_W(CntW)) dut (
        .clk        (clk),
        .reset      (reset),
        .char       (char),
        .freq       (freq),
        .cnt_clr    (cnt_clr),
        .format_type(format_type),
        .error_code (error_code),
        .cap_time   (cap_time),
        .cap_pc     (cap_pc),
        .cap_tgt    (cap_tgt),
        .cap_data   (cap_data),
        .line_cnt   (line_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      fmt;
        logic [3:0]      err;
        logic [31:0]     t, pc, tgt, data;
        logic [CntW-1:0] lc, ec;
    } exp_t;

    exp_t            sb_q[$];
    int              checks = 0;
    int              errors = 0;
    logic [CntW-1:0] exp_lc = '0;
    logic [CntW-1:0] exp_ec = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every non-idle report must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset && format_type != 2'd0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_report: got format %0d expected none at %0t",
                         format_type, $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("format_type", {30'd0, format_type}, {30'd0, e.fmt});
                chk("error_code", {28'd0, error_code}, {28'd0, e.err});
                chk("cap_time", cap_time, e.t);
                chk("cap_pc", cap_pc, e.pc);
                chk("cap_tgt", cap_tgt, e.tgt);
                chk("cap_data", cap_data, e.data);
                chk("line_cnt", 32'(line_cnt), 32'(e.lc));
                chk("err_cnt", 32'(err_cnt), 32'(e.ec));
            end
        end
    end

    task automatic send_line(input string s, input bit rep, input logic [1:0] fmt,
                             input logic [3:0] err, input logic [31:0] t, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic [31:0] data, input bit clr);
        for (int i = 0; i < s.len(); i++) begin
            char = s[i];
            if (rep && s[i] == "#") begin
                exp_t e;
                cnt_clr = clr;
                if (clr) begin
                    exp_lc = '0;
                    exp_ec = '0;
                end else begin
                    if (exp_lc != '1) exp_lc = exp_lc + 1'b1;
                    if (err != 4'd0 && exp_ec != '1) exp_ec = exp_ec + 1'b1;
                end
                e.fmt = fmt; e.err = err; e.t = t; e.pc = pc; e.tgt = tgt; e.data = data;
                e.lc = exp_lc; e.ec = exp_ec;
                sb_q.push_back(e);
            end
            @(posedge clk);
            #1;
            cnt_clr = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        char = " ";
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_format"}, {30'd0, format_type}, 32'd0);
        chk({tag, "_error"}, {28'd0, error_code}, 32'd0);
        chk({tag, "_cap_time"}, cap_time, 32'd0);
        chk({tag, "_cap_pc"}, cap_pc, 32'd0);
        chk({tag, "_cap_tgt"}, cap_tgt, 32'd0);
        chk({tag, "_cap_data"}, cap_data, 32'd0);
        chk({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);

        freq = 16'd4;
        send_line("^10@00003000: $3 <= 0000abcd#", 1, 2'd1, 4'b0000, 10, 32'h3000, 3,
                  32'h0000abcd, 0);
        idle(2);
        freq = 16'd8;
        send_line("^6@00003001: *00003000 <= 00000001#", 1, 2'd2, 4'b0111, 6, 32'h3001,
                  32'h3000, 1, 0);
        idle(2);
        freq = 16'd2;
        send_line("^5@00003000: $32 <= 00000000#", 1, 2'd1, 4'b1000, 5, 32'h3000, 32, 0, 0);
        idle(2);
        send_line("^5@00003000: $12345 <= 00000000#", 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        freq = 16'd4;
        send_line("^1@0000300^2@00003004: $1<=00000000#", 1, 2'd1, 4'b0000, 2, 32'h3004, 1,
                  0, 0);
        idle(2);
        send_line("^3@0000300: $1 <= 00000000#", 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        send_line("^12345@00003000: $1 <= 00000000#", 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Back-to-back lines with no gap between '#' and '^'.
        send_line("^8@00003008: *00000010 <= deadbeef#", 1, 2'd2, 4'b0000, 8, 32'h3008,
                  32'h10, 32'hdeadbeef, 0);
        send_line("^12@0000300c: $31 <= 12345678#", 1, 2'd1, 4'b0000, 12, 32'h300c, 31,
                  32'h12345678, 0);
        idle(2);
        freq = 16'd16;
        send_line("^16@00003000: $1 <= 0000000F#", 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        send_line("^16@00004ffc: *00002ffc <= 00000000#", 1, 2'd2, 4'b0000, 16, 32'h4ffc,
                  32'h2ffc, 0, 0);
        idle(2);
        send_line("^4@00002ffc: *00002ffe <= 00000000#", 1, 2'd2, 4'b0111, 4, 32'h2ffc,
                  32'h2ffe, 0, 0);
        idle(2);

        // Reset asserted in the middle of the address field.
        send_line("^1@00003000: *0000", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_lc = '0;
        exp_ec = '0;
        idle(2);
        reset = 1'b1;
        freq = 16'd4;
        send_line("^10@00003000: $3 <= 0000abcd#", 1, 2'd1, 4'b0000, 10, 32'h3000, 3,
                  32'h0000abcd, 0);
        idle(1);

        // Saturation of the line counter, then clear on the same edge as a '#'.
        for (int k = 0; k < 8; k++) begin
            send_line("^2@00003000: $0 <= 00000000#", 1, 2'd1, 4'b0000, 2, 32'h3000, 0, 0, 0);
        end
        idle(1);
        chk("line_cnt_saturated", 32'(line_cnt), 32'd7);
        send_line("^2@00003000: $0 <= 00000000#", 1, 2'd1, 4'b0000, 2, 32'h3000, 0, 0, 1);
        idle(3);

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
